// File: rtl/sm_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sm_clk_ctrl_pkg
// Purpose : Shared types and helpers for the CPU clock controller.
//           - state_e   : controller FSM states
//           - clamp_div : limits the half-period exponent to a maximum
// Revision: 1.0 - initial release
// ============================================================================
package sm_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_STEP_HI = 3'd3,
    ST_STEP_LO = 3'd4
  } state_e;

  // Half-period exponent, limited to max_d.
  function automatic int clamp_div(input int d, input int max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_clk_ctrl_step_filter.sv
`default_nettype none
// ============================================================================
// Module  : sm_step_filter
// Purpose : Synchronises and debounces the raw single-step button and emits
//           a one-cycle request on each accepted press.
// Ports   : clkIn   - clock
//           rst_n   - synchronous active-low reset
//           stepBtn - raw button level (asynchronous)
//           stepReq - one-cycle pulse on rising edge of the filtered level
// Revision: 1.0 - initial release
// ============================================================================
module sm_step_filter
  import sm_clk_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STEP_FILTER = 16
) (
  input  logic clkIn,
  input  logic rst_n,
  input  logic stepBtn,
  output logic stepReq
);

  localparam int FC_W = (STEP_FILTER > 1) ? $clog2(STEP_FILTER) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(STEP_FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FC_W-1:0]        filtCnt_q, filtCnt_d;
  logic                   filt_q, filt_d;
  logic                   filtDly_q;
  logic                   step;

  assign step = sync_q[SYNC_STAGES-1];

  // A level change is accepted only after it has been stable for
  // STEP_FILTER consecutive cycles; any return to the filtered level restarts.
  always_comb begin
    filtCnt_d = '0;
    filt_d    = filt_q;
    if (step != filt_q) begin
      if (filtCnt_q == FC_LAST) begin
        filt_d = step;
      end else begin
        filtCnt_d = filtCnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      sync_q    <= '0;
      filtCnt_q <= '0;
      filt_q    <= 1'b0;
      filtDly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], stepBtn};
      filtCnt_q <= filtCnt_d;
      filt_q    <= filt_d;
      filtDly_q <= filt_q;
    end
  end

  assign stepReq = filt_q & ~filtDly_q;

endmodule
`default_nettype wire

// File: rtl/sm_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sm_clk_ctrl
// Purpose : Glitch-free registered CPU clock divider with run, halt and
//           single-step modes, synchronised/debounced controls, a rise strobe
//           and a CPU cycle counter.
// Ports   : clkIn    - sole clock
//           rst_n    - synchronous active-low reset
//           devide   - half-period exponent (clamped to MAX_DIV)
//           enable   - 1 = free run, 0 = halt (asynchronous)
//           stepBtn  - raw single-step button
//           clkOut   - registered divided clock
//           clkRise  - one-cycle strobe in the first cycle clkOut reads 1
//           halted   - high while in HALT
//           cycleCnt - clkOut rising edges since reset (wraps)
// Option  : SM_CLK_CTRL_BREAK_EN adds breakEn / breakCnt / breakHit, which
//           stop free-running when cycleCnt reaches breakCnt.
// Revision: 1.0 - initial release
// ============================================================================
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH   = 4,
  parameter int MAX_DIV     = 15,
  parameter int SYNC_STAGES = 2,
  parameter int STEP_FILTER = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clkIn,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] devide,
  input  logic                 enable,
  input  logic                 stepBtn,
  output logic                 clkOut,
  output logic                 clkRise,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycleCnt
`ifdef SM_CLK_CTRL_BREAK_EN
  ,
  input  logic                 breakEn,
  input  logic [CNT_WIDTH-1:0] breakCnt,
  output logic                 breakHit
`endif
);

  localparam int HC_W = (MAX_DIV < 1) ? 1 : MAX_DIV;

  logic [SYNC_STAGES-1:0] enSync_q;
  logic [DIV_WIDTH-1:0]   divSync_q [SYNC_STAGES];
  state_e                 state_q, state_d;
  logic [HC_W-1:0]        halfCnt_q, halfCnt_d, halfCntNext;
  logic                   clkOut_q, clkOut_d;
  logic                   clkRise_q, rise;
  logic [CNT_WIDTH-1:0]   cycleCnt_q, cycleCnt_d;
  logic [HC_W:0]          thresh;
  logic                   term, enSync, runOk, stepReq;
  int                     dClamp;

  sm_step_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .STEP_FILTER (STEP_FILTER)
  ) u_step_filter (
    .clkIn   (clkIn),
    .rst_n   (rst_n),
    .stepBtn (stepBtn),
    .stepReq (stepReq)
  );

  assign enSync = enSync_q[SYNC_STAGES-1];

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      enSync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) divSync_q[i] <= '0;
    end else begin
      enSync_q     <= {enSync_q[SYNC_STAGES-2:0], enable};
      divSync_q[0] <= devide;
      for (int i = 1; i < SYNC_STAGES; i++) divSync_q[i] <= divSync_q[i-1];
    end
  end

`ifdef SM_CLK_CTRL_BREAK_EN
  logic breakHit_q, breakHit_d;

  // Once a breakpoint hits, free-running stays blocked until enable is
  // seen low, so a fresh 0->1 is needed to resume.
  always_comb begin
    breakHit_d = breakHit_q;
    if (!enSync) begin
      breakHit_d = 1'b0;
    end else if (state_q == ST_RUN && rise && breakEn &&
                 (cycleCnt_q + CNT_WIDTH'(1)) == breakCnt) begin
      breakHit_d = 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rst_n) breakHit_q <= 1'b0;
    else        breakHit_q <= breakHit_d;
  end

  assign breakHit = breakHit_q;
  assign runOk    = enSync & ~breakHit_q;
`else
  assign runOk    = enSync;
`endif

  // ">=" rather than "==" so that shrinking devide mid-phase ends the phase
  // at the next edge instead of wrapping the counter.
  always_comb begin
    dClamp      = clamp_div(int'(divSync_q[SYNC_STAGES-1]), MAX_DIV);
    thresh      = ((HC_W+1)'(1) << dClamp) - (HC_W+1)'(1);
    term        = ({1'b0, halfCnt_q} >= thresh);
    halfCntNext = term ? '0 : halfCnt_q + HC_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    halfCnt_d  = halfCnt_q;
    clkOut_d   = clkOut_q;
    rise       = 1'b0;
    case (state_q)
      ST_HALT: begin
        halfCnt_d = '0;
        if (runOk) begin
          state_d = ST_RUN;
        end else if (stepReq) begin
          state_d  = ST_STEP_HI;
          clkOut_d = 1'b1;
          rise     = 1'b1;
        end
      end
      ST_RUN: begin
        halfCnt_d = halfCntNext;
        if (!runOk) begin
          // Low phase: stop at once. High phase: let it finish (no runt).
          if (!clkOut_q) begin
            state_d   = ST_HALT;
            halfCnt_d = '0;
          end else if (term) begin
            state_d  = ST_HALT;
            clkOut_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (term) begin
          clkOut_d = ~clkOut_q;
          rise     = ~clkOut_q;
        end
      end
      ST_DRAIN: begin
        halfCnt_d = halfCntNext;
        if (term) begin
          clkOut_d = 1'b0;
          state_d  = runOk ? ST_RUN : ST_HALT;
        end else if (runOk) begin
          state_d = ST_RUN;
        end
      end
      ST_STEP_HI: begin
        halfCnt_d = halfCntNext;
        if (term) begin
          clkOut_d = 1'b0;
          state_d  = ST_STEP_LO;
        end
      end
      ST_STEP_LO: begin
        halfCnt_d = halfCntNext;
        if (term) state_d = ST_HALT;
      end
      default: begin
        state_d   = ST_HALT;
        halfCnt_d = '0;
        clkOut_d  = 1'b0;
      end
    endcase
    cycleCnt_d = rise ? cycleCnt_q + CNT_WIDTH'(1) : cycleCnt_q;
  end

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      state_q    <= ST_HALT;
      halfCnt_q  <= '0;
      clkOut_q   <= 1'b0;
      clkRise_q  <= 1'b0;
      cycleCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      halfCnt_q  <= halfCnt_d;
      clkOut_q   <= clkOut_d;
      clkRise_q  <= rise;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign clkOut   = clkOut_q;
  assign clkRise  = clkRise_q;
  assign cycleCnt = cycleCnt_q;
  assign halted   = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_sm_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sm_clk_ctrl
// Purpose : Self-checking bench for sm_clk_ctrl (MAX_DIV=3, CNT_WIDTH=8 so
//           clamping and counter wrap are reachable quickly).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sm_clk_ctrl;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] devide;
  logic          enable;
  logic          stepBtn;
  logic          clkOut, clkRise, halted;
  logic [CW-1:0] cycleCnt;
`ifdef SM_CLK_CTRL_BREAK_EN
  logic          breakEn;
  logic [CW-1:0] breakCnt;
  logic          breakHit;
`endif

  always #5 clk = ~clk;

  sm_clk_ctrl #(
    .DIV_WIDTH   (DW),
    .MAX_DIV     (3),
    .SYNC_STAGES (2),
    .STEP_FILTER (16),
    .CNT_WIDTH   (CW)
  ) dut (
    .clkIn    (clk),
    .rst_n    (rst_n),
    .devide   (devide),
    .enable   (enable),
    .stepBtn  (stepBtn),
    .clkOut   (clkOut),
    .clkRise  (clkRise),
    .halted   (halted),
    .cycleCnt (cycleCnt)
`ifdef SM_CLK_CTRL_BREAK_EN
    ,
    .breakEn  (breakEn),
    .breakCnt (breakCnt),
    .breakHit (breakHit)
`endif
  );

  int            total = 0;
  int            bad   = 0;
  logic          prev_out = 1'b0;
  logic [CW-1:0] exp_cnt  = '0;

  typedef struct {
    logic [DW-1:0] dv;
    int            half;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; sample just after the edge. The rise strobe must match the
  // observed 0->1 transitions of clkOut, and exp_cnt counts those rises.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("clkRise", clkRise, clkOut & ~prev_out);
    if (clkOut && !prev_out) exp_cnt = exp_cnt + 1'b1;
    prev_out = clkOut;
    if (!rst_n) begin
      exp_cnt  = '0;
      prev_out = 1'b0;
    end
  endtask

  task automatic wait_halt(input string nm);
    for (int n = 0; n < 200 && halted !== 1'b1; n++) tick();
    chk(nm, halted, 1);
  endtask

  task automatic wait_high(input string nm);
    for (int n = 0; n < 200 && clkOut !== 1'b1; n++) tick();
    chk(nm, clkOut, 1);
  endtask

  // Called in the first high cycle; returns high and low phase lengths
  // and leaves the bench at the next rise.
  task automatic measure(output int hi, output int lo);
    hi = 1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (clkOut !== 1'b1) break;
      hi++;
    end
    lo = 1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (clkOut !== 1'b0) break;
      lo++;
    end
  endtask

  initial begin
    int hi, lo, seen;
    tbl[0] = '{dv: 4'd0,  half: 1};
    tbl[1] = '{dv: 4'd1,  half: 2};
    tbl[2] = '{dv: 4'd2,  half: 4};
    tbl[3] = '{dv: 4'd3,  half: 8};
    tbl[4] = '{dv: 4'd15, half: 8};
    tbl[5] = '{dv: 4'd9,  half: 8};

    rst_n = 1'b0; devide = 4'd2; enable = 1'b1; stepBtn = 1'b0;
`ifdef SM_CLK_CTRL_BREAK_EN
    breakEn = 1'b0; breakCnt = '0;
`endif

    // Reset with enable already high
    repeat (3) tick();
    chk("rst_clkOut", clkOut, 0);
    chk("rst_halted", halted, 1);
    chk("rst_cnt", cycleCnt, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("rst_sync_halt", halted, 1);
    tick();
    chk("rst_run", halted, 0);
    seen = 0;
    repeat (3) begin tick(); if (clkOut) seen++; end
    chk("first_low", seen, 0);
    tick();
    chk("first_rise", clkOut, 1);
    chk("first_cnt", cycleCnt, 1);

    // Table: half-period per devide value, including clamped ones
    for (int i = 0; i < 6; i++) begin
      enable = 1'b0;
      wait_halt("tbl_halt");
      devide = tbl[i].dv;
      repeat (3) tick();
      enable = 1'b1;
      wait_high("tbl_rise");
      measure(hi, lo);
      chk("tbl_hi", hi, tbl[i].half);
      chk("tbl_lo", lo, tbl[i].half);
      chk("tbl_cnt", cycleCnt, exp_cnt);
    end

    // Halt requested during the high phase: full high phase, then halt
    enable = 1'b0;
    wait_halt("halt_pre");
    devide = 4'd2;
    repeat (3) tick();
    enable = 1'b1;
    wait_high("halt_rise");
    enable = 1'b0;
    hi = 1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (clkOut !== 1'b1) break;
      hi++;
    end
    chk("halt_hi", hi, 4);
    chk("halt_halted", halted, 1);
    seen = 0;
    repeat (20) begin tick(); if (clkOut) seen++; end
    chk("halt_stays_low", seen, 0);
    chk("halt_cnt", cycleCnt, exp_cnt);

    // Single step, devide=1, button held 20 cycles
    devide = 4'd1;
    repeat (3) tick();
    stepBtn = 1'b1;
    seen = 0;
    repeat (18) begin tick(); if (clkOut) seen++; end
    chk("step_early", seen, 0);
    tick(); chk("step_rise", clkOut, 1);
    tick(); chk("step_hi2", clkOut, 1);
    stepBtn = 1'b0;
    tick(); chk("step_lo1", clkOut, 0); chk("step_busy", halted, 0);
    tick(); chk("step_lo2", clkOut, 0);
    tick(); chk("step_done", halted, 1);
    seen = 0;
    repeat (40) begin tick(); if (clkOut) seen++; end
    chk("step_single", seen, 0);
    // 10-cycle bounce must be rejected
    stepBtn = 1'b1;
    repeat (10) tick();
    stepBtn = 1'b0;
    seen = 0;
    repeat (40) begin tick(); if (clkOut) seen++; end
    chk("bounce", seen, 0);
    chk("step_cnt", cycleCnt, exp_cnt);

    // Counter wrap at 8 bits
    devide = 4'd0;
    repeat (3) tick();
    enable = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      tick();
      if (exp_cnt == 8'hFF) break;
    end
    chk("cnt_ff", cycleCnt, 8'hFF);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (clkRise) break;
    end
    chk("cnt_wrap", cycleCnt, 0);

`ifdef SM_CLK_CTRL_BREAK_EN
    // Breakpoint after 5 rises; no restart until enable cycles low
    enable = 1'b0;
    wait_halt("brk_pre");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    breakEn = 1'b1; breakCnt = 8'd5; devide = 4'd0; enable = 1'b1;
    repeat (100) tick();
    chk("brk_rises", exp_cnt, 5);
    chk("brk_cnt", cycleCnt, 5);
    chk("brk_hit", breakHit, 1);
    chk("brk_halted", halted, 1);
    enable = 1'b0;
    repeat (5) tick();
    chk("brk_clear", breakHit, 0);
    enable = 1'b1;
    repeat (10) tick();
    chk("brk_rerun", exp_cnt > 8'd5, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
